pool_fc_layer: RTL

//  Fully-connected stage directly downstream of the pooled-feature banks (4 banks x 3 channels,

---
 rtl/pool_fc_layer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/pool_fc_layer.sv
// rtl/pool_fc_layer.sv - fully-connected MAC stage over the four pooled-feature banks
// Streams every pooled word per neuron, MACs against ROM weights, emits a shifted/saturated score.
module pool_fc_layer #(
  parameter int BD      = 18,
  parameter int WD      = 18,
  parameter int ADDR_W  = 11,
  parameter int N_WORDS = 256,
  parameter int N_OUT   = 10,
  parameter int ACC_W   = 48,
  parameter int SHIFT   = 12,
  parameter int OUT_W   = 18,
  parameter int RELU    = 1,
  parameter int RD_LAT  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    rden,
  output logic [ADDR_W-1:0]       rd_addr,
  output logic [1:0]              bank_sel,
  input  logic [12*BD-1:0]        pool_q,
  output logic                    wt_rden,
  output logic [15:0]             wt_addr,
  input  logic [3*WD-1:0]         wt_q,
  output logic signed [OUT_W-1:0] result,
  output logic [3:0]              res_idx,
  output logic                    res_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int PW        = BD + WD;
  localparam int DRAIN_CYC = RD_LAT + 2;
  localparam int DW        = $clog2(DRAIN_CYC + 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [1:0]               bank_q, bank_d;
  logic [3:0]               o_q, o_d;
  logic [DW-1:0]            drain_q, drain_d;
  logic [RD_LAT-1:0]        vld_dly_q, vld_dly_d;
  logic [RD_LAT-1:0][1:0]   bank_dly_q, bank_dly_d;
  logic                     x_v_q, x_v_d;
  logic signed [BD-1:0]     x_q [3];
  logic signed [BD-1:0]     x_d [3];
  logic signed [WD-1:0]     w_q [3];
  logic signed [WD-1:0]     w_d [3];
  logic                     p_v_q, p_v_d;
  logic signed [PW-1:0]     p_q [3];
  logic signed [PW-1:0]     p_d [3];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  result_q, result_d;
  logic [3:0]               res_idx_q, res_idx_d;

  logic                     last_addr, last_read;
  logic [RD_LAT:0]          vld_shift;
  logic [1:0]               tap_bank;
  logic signed [ACC_W-1:0]  prod_sum, shifted;
  logic signed [OUT_W-1:0]  score;

  assign last_addr = (addr_q == ADDR_W'(N_WORDS - 1));
  assign last_read = last_addr && (bank_q == 2'd3);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    o_d     = o_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          addr_d  = '0;
          bank_d  = '0;
          o_d     = '0;
        end
      end
      S_READ: begin
        if (last_addr) begin
          addr_d = '0;
          bank_d = bank_q + 2'd1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
        if (last_read) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DW'(1);
        if (drain_q == DW'(DRAIN_CYC - 1)) state_d = S_OUT;
      end
      S_OUT: begin
        if (o_q == 4'(N_OUT - 1)) begin
          state_d = S_DONE;
        end else begin
          o_d     = o_q + 4'd1;
          state_d = S_READ;
        end
      end
      S_DONE: begin
        o_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address outputs are forced to 0 whenever no read is in flight.
  always_comb begin
    rden     = (state_q == S_READ);
    wt_rden  = rden;
    rd_addr  = rden ? addr_q : '0;
    bank_sel = rden ? bank_q : '0;
    wt_addr  = rden ? (16'(o_q) * 16'(4 * N_WORDS) + 16'(bank_q) * 16'(N_WORDS) + 16'(addr_q))
                    : 16'd0;
  end

  // Valid tag and bank select travel alongside the read data.
  always_comb begin
    vld_shift     = {vld_dly_q, rden};
    vld_dly_d     = vld_shift[RD_LAT-1:0];
    bank_dly_d[0] = bank_sel;
    for (int i = 1; i < RD_LAT; i++) bank_dly_d[i] = bank_dly_q[i-1];
    tap_bank = bank_dly_q[RD_LAT-1];
    x_v_d    = vld_dly_q[RD_LAT-1];
    for (int k = 0; k < 3; k++) begin
      x_d[k] = pool_q[(3 * int'(tap_bank) + k) * BD +: BD];
      w_d[k] = wt_q[k * WD +: WD];
    end
  end

  always_comb begin
    p_v_d = x_v_q;
    for (int k = 0; k < 3; k++) p_d[k] = PW'(x_q[k]) * PW'(w_q[k]);
  end

  always_comb begin
    prod_sum = {{(ACC_W - PW){p_q[0][PW-1]}}, p_q[0]}
             + {{(ACC_W - PW){p_q[1][PW-1]}}, p_q[1]}
             + {{(ACC_W - PW){p_q[2][PW-1]}}, p_q[2]};
    acc_d = acc_q;
    if (state_q == S_IDLE || state_q == S_OUT) begin
      acc_d = '0;
    end else if (p_v_q) begin
      acc_d = acc_q + prod_sum;
    end
  end

  always_comb begin
    shifted = acc_q >>> SHIFT;
    if (shifted > SAT_HI) begin
      score = SAT_HI[OUT_W-1:0];
    end else if (shifted < SAT_LO) begin
      score = SAT_LO[OUT_W-1:0];
    end else begin
      score = shifted[OUT_W-1:0];
    end
    if (RELU != 0 && score < 0) score = '0;
  end

  // Score is presented live during OUT and held afterwards.
  always_comb begin
    result_d  = result_q;
    res_idx_d = res_idx_q;
    if (state_q == S_OUT) begin
      result_d  = score;
      res_idx_d = o_q;
    end
    result    = result_d;
    res_idx   = res_idx_d;
    res_valid = (state_q == S_OUT);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      bank_q     <= '0;
      o_q        <= '0;
      drain_q    <= '0;
      vld_dly_q  <= '0;
      bank_dly_q <= '0;
      x_v_q      <= 1'b0;
      p_v_q      <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      res_idx_q  <= '0;
      for (int k = 0; k < 3; k++) begin
        x_q[k] <= '0;
        w_q[k] <= '0;
        p_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      o_q        <= o_d;
      drain_q    <= drain_d;
      vld_dly_q  <= vld_dly_d;
      bank_dly_q <= bank_dly_d;
      x_v_q      <= x_v_d;
      p_v_q      <= p_v_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      res_idx_q  <= res_idx_d;
      for (int k = 0; k < 3; k++) begin
        x_q[k] <= x_d[k];
        w_q[k] <= w_d[k];
        p_q[k] <= p_d[k];
      end
    end
  end

endmodule
